// File: rtl/count_display_driver.sv
// count_display_driver: shows live count and underflow tally on a 2-digit muxed 7-seg display
module count_display_driver #(
  parameter int REFRESH_DIV    = 1000,
  parameter int DP_HOLD        = 16,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cnt_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int TW = $clog2(DP_HOLD + 1);
  localparam logic [111:0] HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  typedef enum logic {DIG0, DIG1} state_t;
  state_t          state;
  logic [3:0]      cnt_q, wrap_cnt, digit;
  logic            primed, wrap, slot_end, dp_on;
  logic [TW-1:0]   dp_timer;
  logic [PW-1:0]   presc;
  logic [6:0]      seg_on;
  logic [1:0]      an_on;
  assign wrap     = primed && cnt_q == 4'h0 && cnt_in == 4'hF;
  assign slot_end = presc == PW'(REFRESH_DIV - 1);
  // active-high view of what the current slot should put on the pins
  always_comb begin
    digit  = state == DIG1 ? wrap_cnt : cnt_q;
    seg_on = HEX[7*digit +: 7];
    dp_on  = state == DIG0 && dp_timer != '0;
    an_on  = state == DIG1 ? 2'b10 : 2'b01;
  end
  // sampling, wrap tracking, slot sequencing and registered pin drive
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= 4'h0;
      primed   <= 1'b0;
      wrap_cnt <= 4'h0;
      dp_timer <= '0;
      presc    <= '0;
      state    <= DIG0;
      seg      <= {7{SEG_ACTIVE_LOW}};
      dp       <= SEG_ACTIVE_LOW;
      an       <= {2{AN_ACTIVE_LOW}};
    end else begin
      cnt_q    <= cnt_in;
      primed   <= 1'b1;
      wrap_cnt <= wrap ? wrap_cnt + 4'd1 : wrap_cnt;
      dp_timer <= wrap ? TW'(DP_HOLD) : (dp_timer != '0 ? dp_timer - TW'(1) : dp_timer);
      presc    <= slot_end ? '0 : presc + PW'(1);
      state    <= slot_end ? (state == DIG0 ? DIG1 : DIG0) : state;
      seg      <= seg_on ^ {7{SEG_ACTIVE_LOW}};
      dp       <= dp_on ^ SEG_ACTIVE_LOW;
      an       <= an_on ^ {2{AN_ACTIVE_LOW}};
    end
  end
endmodule

// File: tb/tb_count_display_driver.sv
// tb_count_display_driver: directed vectors against hand-computed display patterns
module tb_count_display_driver;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cnt_in = 4'h0;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;
  int vecs = 0, errs = 0, k = 0;
  count_display_driver #(
    .REFRESH_DIV(4), .DP_HOLD(3), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .seg(seg), .dp(dp), .an(an)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  // k = index of the output edge since reset release (1 = first)
  task automatic tick();
    @(posedge clk);
    #1;
    k = reset ? 0 : k + 1;
  endtask
  function automatic bit dig1();
    return ((k - 1) / 4) % 2 == 1;
  endfunction
  task automatic wrap_once();
    cnt_in = 4'h0;
    tick();
    cnt_in = 4'hF;
    tick();
  endtask
  task automatic show_dig1(input string tag, input logic [6:0] exp);
    bit seen = 0;
    cnt_in = 4'hF;
    tick();
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (dig1()) begin
        check({tag, "_an"}, 7'(an), 7'(2'b01));
        check({tag, "_seg"}, seg, exp);
        seen = 1;
      end
    end
  endtask
  task automatic check_off(input string tag);
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_dp"}, 7'(dp), 7'd1);
    check({tag, "_an"}, 7'(an), 7'(2'b11));
  endtask
  initial begin
    reset = 1'b1;
    cnt_in = 4'h0;
    repeat (3) tick();
    check_off("t1_rst");
    reset = 1'b0;
    cnt_in = 4'h5;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("t2_an", 7'(an), 7'(dig1() ? 2'b01 : 2'b10));
      check("t2_dp", 7'(dp), 7'd1);
      if (i > 1) check("t2_seg", seg, dig1() ? 7'b1000000 : 7'b0010010);
    end
    cnt_in = 4'h1;
    tick();
    cnt_in = 4'h0;
    tick();
    cnt_in = 4'hF;
    tick();
    check("t3_dp_pre", 7'(dp), 7'd1);
    tick();
    check("t3_dp_lit", 7'(dp), 7'd0);
    check("t3_seg0", seg, 7'b0001110);
    check("t3_an0", 7'(an), 7'(2'b10));
    tick();
    check("t3_an1", 7'(an), 7'(2'b01));
    check("t3_seg1", seg, 7'b1111001);
    check("t3_dp1", 7'(dp), 7'd1);
    repeat (3) tick();
    tick();
    check("t3_an_back", 7'(an), 7'(2'b10));
    check("t3_dp_done", 7'(dp), 7'd1);
    cnt_in = 4'h0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    check_off("t4_rst");
    reset = 1'b0;
    cnt_in = 4'hF;
    tick();
    check("t4_an", 7'(an), 7'(2'b10));
    check("t4_seg", seg, 7'b1000000);
    check("t4_dp", 7'(dp), 7'd1);
    tick();
    check("t4_seg_f", seg, 7'b0001110);
    check("t4_dp2", 7'(dp), 7'd1);
    show_dig1("t4_nowrap", 7'b1000000);
    repeat (15) wrap_once();
    show_dig1("t5_fifteen", 7'b0001110);
    repeat (2) wrap_once();
    show_dig1("t5_roll", 7'b1111001);
    repeat (2) wrap_once();
    tick();
    reset = 1'b1;
    tick();
    check_off("t6_rst");
    reset = 1'b0;
    tick();
    check("t6_an", 7'(an), 7'(2'b10));
    check("t6_dp", 7'(dp), 7'd1);
    check("t6_seg", seg, 7'b1000000);
    show_dig1("t6_wrapcnt", 7'b1000000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
